dip_debouncer: RTL and testbench

Synchronizes and debounces the two 4-bit DIP switch banks before they reach the display time-multiplexer and the LED sum logic. Each of the 8 switch bits passes through a 2-FF synchronizer and a per-bit stability counter. The counter samples on a shared prescaled tick. The block outputs clean, glitch-free switch values plus a one-cycle change strobe. It runs on the 6 MHz HSOSC clock.

---
 rtl/debounce_pkg.sv | 10 +
 rtl/bit_debouncer.sv | 53 +++++
 rtl/dip_debouncer.sv | 63 ++++++
 tb/tb_dip_debouncer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants and types for the DIP switch debouncer.
package debounce_pkg;

  localparam int unsigned DEFAULT_SAMPLE_DIV     = 6000;
  localparam int unsigned DEFAULT_STABLE_SAMPLES = 8;
  localparam int unsigned NUM_SW_BITS            = 8;

  typedef logic [NUM_SW_BITS-1:0] sw_vec_t;

endpackage

// File: rtl/bit_debouncer.sv
// Single-bit stability qualifier: accepts a new value after STABLE_SAMPLES
// consecutive ticks on which the synchronized input differs from the output.
module bit_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sync,
  output logic db,
  output logic flip
);

  localparam int unsigned   CW      = $clog2(STABLE_SAMPLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_SAMPLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q,  db_d;

  // flip is asserted in the tick cycle that commits a new value, so the
  // parent can register it alongside db_q.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    flip  = 1'b0;
    if (tick) begin
      if (sync == db_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        db_d  = sync;
        cnt_d = '0;
        flip  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      db_q  <= db_d;
    end
  end

  assign db = db_q;

endmodule

// File: rtl/dip_debouncer.sv
// Synchronizes and debounces two 4-bit DIP banks; pulses changed for one
// cycle whenever any debounced bit updates.
module dip_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV     = DEFAULT_SAMPLE_DIV,
  parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  output logic [3:0] s1_db,
  output logic [3:0] s2_db,
  output logic       changed
);

  localparam int unsigned   PW   = $clog2(SAMPLE_DIV);
  localparam logic [PW-1:0] PMAX = PW'(SAMPLE_DIV - 1);

  sw_vec_t       sync1_q, sync2_q;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick;
  sw_vec_t       db;
  sw_vec_t       flip;
  logic          changed_q, changed_d;

  assign tick      = (presc_q == PMAX);
  assign presc_d   = tick ? '0 : presc_q + PW'(1);
  assign changed_d = |flip;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      presc_q   <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= {s2, s1};
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      changed_q <= changed_d;
    end
  end

  for (genvar i = 0; i < NUM_SW_BITS; i++) begin : g_bit
    bit_debouncer #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .sync (sync2_q[i]),
      .db   (db[i]),
      .flip (flip[i])
    );
  end

  assign s1_db   = db[3:0];
  assign s2_db   = db[7:4];
  assign changed = changed_q;

endmodule

// File: tb/tb_dip_debouncer.sv
// Scoreboard bench for dip_debouncer with SAMPLE_DIV=4, STABLE_SAMPLES=3.
module tb_dip_debouncer;

  localparam int unsigned DIV = 4;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  s1;
    logic [3:0]  s2;
  } exp_t;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] s1    = '0;
  logic [3:0] s2    = '0;
  logic [3:0] s1_db, s2_db;
  logic       changed;

  int unsigned cyc       = 0;
  logic        rst_seen  = 1'b1;
  int unsigned rel       = 0;
  int unsigned n_cmp     = 0;
  int unsigned n_err     = 0;
  logic [3:0]  held_s1   = '0;
  logic [3:0]  held_s2   = '0;
  exp_t        exp_q[$];

  dip_debouncer #(
    .SAMPLE_DIV    (4),
    .STABLE_SAMPLES(3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .s1     (s1),
    .s2     (s2),
    .s1_db  (s1_db),
    .s2_db  (s2_db),
    .changed(changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_seen <= !reset;
    cyc      <= cyc + 1;
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // Monitor: every output update must be announced by changed and match the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_seen) begin
      chk("rst_changed", changed, 0);
      chk("rst_s1_db", s1_db, 0);
      chk("rst_s2_db", s2_db, 0);
      held_s1 = '0;
      held_s2 = '0;
    end else if (changed) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_changed", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("chg_cycle", cyc, e.cyc);
        chk("chg_s1_db", s1_db, e.s1);
        chk("chg_s2_db", s2_db, e.s2);
        held_s1 = e.s1;
        held_s2 = e.s2;
      end
    end else begin
      chk("hold_s1_db", s1_db, held_s1);
      chk("hold_s2_db", s2_db, held_s2);
    end
  end

  task automatic at_tick(input int unsigned t);
    while (cyc < rel + DIV * t) @(negedge clk);
  endtask

  task automatic expect_at(input int unsigned t, input logic [3:0] e1, input logic [3:0] e2);
    exp_t e;
    e.cyc = rel + DIV * t;
    e.s1  = e1;
    e.s2  = e2;
    exp_q.push_back(e);
  endtask

  initial begin
    reset = 1'b0;
    s1    = 4'hF;
    s2    = 4'h0;
    repeat (5) @(negedge clk);

    // Clean step from reset
    s1 = 4'hA; s2 = 4'h5; reset = 1'b1; rel = cyc;
    expect_at(12 / DIV * 1 == 3 ? 3 : 3, 4'hA, 4'h5);

    at_tick(3);  s1 = 4'h0; s2 = 4'h0; expect_at(6, 4'h0, 4'h0);

    // Bounce rejection: two differing ticks only
    at_tick(6);  s1 = 4'h1;
    at_tick(8);  s1 = 4'h0;

    // Restart on bounce: 2 high, 1 low, 3 high
    at_tick(10); s1 = 4'h1;
    at_tick(12); s1 = 4'h0;
    at_tick(13); s1 = 4'h1; expect_at(16, 4'h1, 4'h0);

    at_tick(16); s1 = 4'h0; expect_at(19, 4'h0, 4'h0);

    // Simultaneous flips on both banks
    at_tick(19); s1 = 4'h3; s2 = 4'h8; expect_at(22, 4'h3, 4'h8);

    // Reset after two qualifying ticks of s2=F
    at_tick(22); s2 = 4'hF;
    at_tick(24); reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1; rel = cyc;
    expect_at(3, 4'h3, 4'hF);

    // Idle with constant inputs: no further pulses allowed
    at_tick(17);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, %0d compared / %0d mismatched", n_cmp, n_err);
    $fatal(1);
  end

endmodule
